// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - single-stage instruction fetch with branch redirect, stall and halt
// The pc drives program memory directly; the returned word is registered into instr_out one edge later.
module instruction_fetch #(
  parameter int          N      = 8,
  parameter int          AddrSz = 6,
  parameter logic [N-1:0] HaltOp = '1
) (
  input  logic              clk,
  input  logic              n_reset,
  output logic [AddrSz-1:0] pc_addr,
  input  logic [N+15:0]     instr_in,
  input  logic              stall,
  input  logic              branch_en,
  input  logic              branch_rel,
  input  logic [AddrSz-1:0] branch_target,
  output logic [N+15:0]     instr_out,
  output logic [AddrSz-1:0] instr_pc,
  output logic              instr_valid,
  output logic              halted
);

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  localparam logic [AddrSz-1:0] PcOne = {{(AddrSz-1){1'b0}}, 1'b1};

  state_t            r_state;
  state_t            w_state_next;
  logic [AddrSz-1:0] r_pc;
  logic [N+15:0]     r_instr;
  logic [AddrSz-1:0] r_instr_pc;
  logic              r_valid;
  logic              w_is_halt;
  logic              w_branch_take;
  logic [AddrSz-1:0] w_branch_pc;

  assign w_is_halt     = (instr_in[N+15:16] == HaltOp);
  assign w_branch_take = branch_en && r_valid && !stall && (r_state == RUN);
  // Same-width addition gives the sign-extended relative target modulo 2^AddrSz.
  assign w_branch_pc   = branch_rel ? (r_instr_pc + branch_target) : branch_target;

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (r_state == RUN && !stall && !w_branch_take && w_is_halt) begin
      w_state_next = HALTED;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_pc       <= '0;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_valid    <= 1'b0;
    end else if (!stall) begin
      if (r_state == HALTED) begin
        r_valid <= 1'b0;
      end else if (w_branch_take) begin
        r_pc    <= w_branch_pc;
        r_valid <= 1'b0;
      end else begin
        r_instr    <= instr_in;
        r_instr_pc <= r_pc;
        r_valid    <= 1'b1;
        if (!w_is_halt) begin
          r_pc <= r_pc + PcOne;
        end
      end
    end
  end

  assign pc_addr     = r_pc;
  assign instr_out   = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_valid;
  assign halted      = (r_state == HALTED);

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed bench for instruction_fetch
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        n_reset;
  logic [5:0]  pc_addr;
  logic [23:0] instr_in;
  logic        stall;
  logic        branch_en;
  logic        branch_rel;
  logic [5:0]  branch_target;
  logic [23:0] instr_out;
  logic [5:0]  instr_pc;
  logic        instr_valid;
  logic        halted;

  logic [23:0] mem [0:63];
  int passed = 0;
  int total  = 0;

  instruction_fetch dut (
    .clk           (clk),
    .n_reset       (n_reset),
    .pc_addr       (pc_addr),
    .instr_in      (instr_in),
    .stall         (stall),
    .branch_en     (branch_en),
    .branch_rel    (branch_rel),
    .branch_target (branch_target),
    .instr_out     (instr_out),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .halted        (halted)
  );

  always #5 clk = ~clk;
  assign instr_in = mem[pc_addr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag, input logic [23:0] e_out, input logic [5:0] e_ipc,
                         input logic e_valid, input logic e_halt, input logic [5:0] e_pc);
    chk({tag, ".instr_out"},   32'(instr_out),   32'(e_out));
    chk({tag, ".instr_pc"},    32'(instr_pc),    32'(e_ipc));
    chk({tag, ".instr_valid"}, 32'(instr_valid), 32'(e_valid));
    chk({tag, ".halted"},      32'(halted),      32'(e_halt));
    chk({tag, ".pc_addr"},     32'(pc_addr),     32'(e_pc));
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 24'(i + 1);
    n_reset = 1'b0; stall = 1'b0; branch_en = 1'b0; branch_rel = 1'b0; branch_target = '0;
    step(); step();
    chk_all("reset", 24'h0, 6'd0, 1'b0, 1'b0, 6'd0);

    // Sequential fetch from reset release
    n_reset = 1'b1;
    step(); chk_all("seq0", 24'h000001, 6'd0, 1'b1, 1'b0, 6'd1);
    step(); chk_all("seq1", 24'h000002, 6'd1, 1'b1, 1'b0, 6'd2);
    step(); chk_all("seq2", 24'h000003, 6'd2, 1'b1, 1'b0, 6'd3);
    step(); step(); step();
    chk_all("seq5", 24'h000006, 6'd5, 1'b1, 1'b0, 6'd6);

    // Relative branch by -2 from instr_pc=5
    branch_en = 1'b1; branch_rel = 1'b1; branch_target = 6'b111110;
    step(); chk_all("rel_bubble", 24'h000006, 6'd5, 1'b0, 1'b0, 6'd3);
    branch_en = 1'b0;
    step(); chk_all("rel_tgt", 24'h000004, 6'd3, 1'b1, 1'b0, 6'd4);

    // Absolute branch to 40
    branch_en = 1'b1; branch_rel = 1'b0; branch_target = 6'd40;
    step(); chk_all("abs_bubble", 24'h000004, 6'd3, 1'b0, 1'b0, 6'd40);
    branch_en = 1'b0;
    step(); chk_all("abs_tgt", 24'd41, 6'd40, 1'b1, 1'b0, 6'd41);

    // Wrap 62, 63, 0, 1
    branch_en = 1'b1; branch_target = 6'd62;
    step(); branch_en = 1'b0;
    step(); chk_all("wrap62", 24'd63, 6'd62, 1'b1, 1'b0, 6'd63);
    step(); chk_all("wrap63", 24'd64, 6'd63, 1'b1, 1'b0, 6'd0);
    step(); chk_all("wrap0",  24'd1,  6'd0,  1'b1, 1'b0, 6'd1);
    step(); chk_all("wrap1",  24'd2,  6'd1,  1'b1, 1'b0, 6'd2);

    // Stall over a pending branch at instr_pc=7
    for (int i = 0; i < 6; i++) step();
    chk_all("pre_stall", 24'd8, 6'd7, 1'b1, 1'b0, 6'd8);
    stall = 1'b1; branch_en = 1'b1; branch_rel = 1'b0; branch_target = 6'd20;
    for (int i = 0; i < 3; i++) begin
      step(); chk_all("stalled", 24'd8, 6'd7, 1'b1, 1'b0, 6'd8);
    end
    stall = 1'b0;
    step(); chk_all("post_stall_br", 24'd8, 6'd7, 1'b0, 1'b0, 6'd20);
    branch_en = 1'b0;
    step(); chk_all("post_stall_tgt", 24'd21, 6'd20, 1'b1, 1'b0, 6'd21);

    // Halt at word 9
    mem[9] = 24'hFF0000;
    branch_en = 1'b1; branch_target = 6'd9;
    step(); branch_en = 1'b0;
    step(); chk_all("halt_cap", 24'hFF0000, 6'd9, 1'b1, 1'b1, 6'd9);
    step(); chk_all("halt_idle", 24'hFF0000, 6'd9, 1'b0, 1'b1, 6'd9);
    branch_en = 1'b1; branch_target = 6'd30;
    step(); step(); chk_all("halt_ignore_br", 24'hFF0000, 6'd9, 1'b0, 1'b1, 6'd9);
    branch_en = 1'b0;

    // Reset out of halt, then sequential restart
    n_reset = 1'b0;
    step(); chk_all("halt_reset", 24'h0, 6'd0, 1'b0, 1'b0, 6'd0);
    n_reset = 1'b1;
    step(); chk_all("restart", 24'd1, 6'd0, 1'b1, 1'b0, 6'd1);

    // Taken branch while fetching the halt word
    for (int i = 0; i < 8; i++) step();
    chk_all("pre_halt_br", 24'd9, 6'd8, 1'b1, 1'b0, 6'd9);
    branch_en = 1'b1; branch_target = 6'd30;
    step(); chk_all("halt_br_bubble", 24'd9, 6'd8, 1'b0, 1'b0, 6'd30);
    branch_en = 1'b0;
    step(); chk_all("halt_br_tgt", 24'd31, 6'd30, 1'b1, 1'b0, 6'd31);

    // Reset during a stall
    stall = 1'b1; n_reset = 1'b0;
    step(); chk_all("stall_reset", 24'h0, 6'd0, 1'b0, 1'b0, 6'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter N, default 8, meaning the opcode/register field width; instruction width = N+16.
REQ-002 SHALL have parameter AddrSz, default 6, meaning the program address width.
REQ-003 SHALL have parameter HaltOp, default all-ones (N bits), meaning the opcode value that halts fetch.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 n_reset  input  1  reset; synchronous, active-low.
REQ-006 pc_addr  output  AddrSz  address driven to program memory; equals internal pc register.
REQ-007 instr_in  input  N+16  instruction returned combinationally by program memory for pc_addr.
REQ-008 stall  input  1  downstream hold request.
REQ-009 branch_en  input  1  branch taken, resolved on the instruction currently in instr_out.
REQ-010 branch_rel  input  1  1 = relative target, 0 = absolute target.
REQ-011 branch_target  input  AddrSz  absolute address or two's-complement offset.
REQ-012 instr_out  output  N+16  registered instruction to decode.
REQ-013 instr_pc  output  AddrSz  address instr_out was fetched from.
REQ-014 instr_valid  output  1  instr_out holds a live instruction.
REQ-015 halted  output  1  fetch stopped by a halt opcode.

Function
REQ-016 SHALL implement a two-state FSM: RUN, HALTED.
REQ-017 Opcode field SHALL be instr_in[N+15:16].
REQ-018 In RUN, no stall, no taken branch: at the edge, instr_out <= instr_in, instr_pc <= pc, instr_valid <= 1, pc <= pc+1 (mod 2^AddrSz); fetch latency is one cycle from pc_addr to instr_out.
REQ-019 PC increment SHALL wrap: pc = 2^AddrSz-1 is followed by pc = 0, with no flag.
REQ-020 A branch is taken only when branch_en=1, instr_valid=1, stall=0 and the state is RUN; otherwise branch_en is ignored.
REQ-021 On a taken branch: pc <= branch_target if branch_rel=0, else pc <= instr_pc + sign-extended branch_target (mod 2^AddrSz); instr_valid <= 0 (one-cycle bubble flushing the sequential fetch); instr_out and instr_pc hold.
REQ-022 stall=1 SHALL freeze pc, instr_out, instr_pc, instr_valid and the FSM state; stall has priority over branch_en.
REQ-023 In RUN, no stall, no taken branch, with opcode(instr_in)==HaltOp: capture per REQ-018 except pc holds; state <= HALTED; halted <= 1 on the same edge.
REQ-024 When a taken branch coincides with a HaltOp fetch, the branch wins: the halt instruction is discarded, and the state stays RUN.
REQ-025 In HALTED: pc holds; the first edge sets instr_valid <= 0 unless stall=1; afterwards instr_valid stays 0; branch_en is ignored; halted stays 1.
REQ-026 HALTED SHALL be left only by reset.
REQ-027 pc_addr SHALL be a direct copy of pc, with no combinational path from any input.

Reset
REQ-028 n_reset=0 at an edge SHALL set pc=0, instr_out=0, instr_pc=0, instr_valid=0, halted=0, state=RUN, regardless of stall, branch_en or state.
REQ-029 Reset mid-operation (including in HALTED or during a stall) SHALL discard all in-flight state.
REQ-030 The first edge with n_reset=1 SHALL capture the instruction at address 0 with instr_valid=1.

Verification
REQ-031 Reset release with memory words 0..3 = 0x000001..0x000004 -> instr_out 0x000001/0x000002/0x000003 with instr_pc 0/1/2 on consecutive cycles, valid=1 from the first edge.
REQ-032 Wrap test, AddrSz=6 -> instr_pc sequence 62, 63, 0, 1 with no gap in instr_valid.
REQ-033 Branch with instr_pc=5, branch_rel=1, target=6'b111110 (-2) -> one cycle with valid=0, then instr_pc=3; absolute target 40 -> instr_pc=40 after the bubble.
REQ-034 stall held for 3 cycles while instr_pc=7 and branch_en=1 -> all outputs are constant for 3 cycles; the branch is taken on the first unstalled edge.
REQ-035 Word 9 = 0xFF0000 (HaltOp) -> instr_pc=9, valid=1, halted=1 for one cycle; then valid=0 and pc_addr=9 held indefinitely; n_reset pulse -> restart at 0 with halted=0.
REQ-036 Taken branch in the same cycle the HaltOp word is fetched -> halted stays 0 and fetch continues at the branch target.
